// File: rtl/alu_serial_slave.sv
// Serial ALU responder: deserialises 11-bit frames, checks count/CRC/opcode,
// computes AND/OR/ADD/SUB with flags and serialises a result or error packet.
module alu_serial_slave (
  input  logic clk,
  input  logic rst_n,
  input  logic sin,
  output logic sout
);

  typedef enum logic [1:0] {IDLE, RX, CALC, TX} state_t;

  localparam logic [5:0] CODE_DATA = 6'b100100;
  localparam logic [5:0] CODE_CRC  = 6'b010010;
  localparam logic [5:0] CODE_OP   = 6'b001001;

  state_t       state, state_next;
  logic [8:0]   rx_sr;     // type bit + payload; the start bit is not stored
  logic [3:0]   rx_cnt;
  logic [3:0]   frm_cnt;
  logic         derr;
  logic [63:0]  data_sr;
  logic [6:0]   cmd;
  logic [54:0]  tx_sr;
  logic [5:0]   tx_cnt;

  logic         stop_now;
  logic         frm_type;
  logic [7:0]   payload;

  assign stop_now = (state == RX) && (rx_cnt == 4'd10);
  assign frm_type = rx_sr[8];
  assign payload  = rx_sr[7:0];

  function automatic logic [3:0] crc4_calc(input logic [67:0] d);
    logic [3:0] c;
    logic       fb;
    c = '0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ d[i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    return c;
  endfunction

  function automatic logic [2:0] crc3_calc(input logic [36:0] d);
    logic [2:0] c;
    logic       fb;
    c = '0;
    for (int i = 36; i >= 0; i--) begin
      fb = c[2] ^ d[i];
      c  = {c[1:0], 1'b0} ^ (fb ? 3'b011 : 3'b000);
    end
    return c;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      IDLE: if (!sin) state_next = RX;
      RX: if (stop_now) begin
        if (!sin || frm_type || frm_cnt == 4'd8) state_next = CALC;
        else                                     state_next = IDLE;
      end
      CALC:    state_next = TX;
      TX:      if (tx_cnt == 6'd1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / datapath logic
  logic [31:0] a, b, c;
  logic [32:0] sum, diff;
  logic [2:0]  op;
  logic        carry, ovf, op_ok, err;
  logic [3:0]  flags;
  logic [2:0]  crc3;
  logic [5:0]  code;
  logic [10:0] err_frame;
  logic [54:0] packet;
  logic        sout_d;

  assign b  = data_sr[63:32];
  assign a  = data_sr[31:0];
  assign op = cmd[6:4];

  always_comb begin
    c     = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    op_ok = 1'b1;
    sum   = {1'b0, b} + {1'b0, a};
    diff  = {1'b0, b} - {1'b0, a};
    case (op)
      3'b000: c = b & a;
      3'b001: c = b | a;
      3'b100: begin
        c     = sum[31:0];
        carry = sum[32];
        ovf   = (b[31] == a[31]) && (c[31] != b[31]);
      end
      3'b101: begin
        c     = diff[31:0];
        carry = diff[32];  // borrow: set exactly when A > B unsigned
        ovf   = (b[31] != a[31]) && (c[31] != b[31]);
      end
      default: op_ok = 1'b0;
    endcase
    flags = {carry, ovf, (c == 32'd0), c[31]};
    crc3  = crc3_calc({c, 1'b0, flags});

    err  = 1'b1;
    code = CODE_DATA;
    if (derr || frm_cnt != 4'd8)                     code = CODE_DATA;
    else if (crc4_calc({b, a, 1'b1, op}) != cmd[3:0]) code = CODE_CRC;
    else if (!op_ok)                                 code = CODE_OP;
    else                                             err  = 1'b0;

    // Parity bit makes frame bits [8:1] XOR to zero.
    err_frame = {3'b011, code, ^{1'b1, code}, 1'b1};
    packet    = err ? {err_frame, 44'd0}
                    : {2'b00, c[31:24], 1'b1, 2'b00, c[23:16], 1'b1,
                       2'b00, c[15:8],  1'b1, 2'b00, c[7:0],   1'b1,
                       3'b010, flags, crc3, 1'b1};
    sout_d    = (state == TX) ? tx_sr[54] : 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sr   <= '0;
      rx_cnt  <= '0;
      frm_cnt <= '0;
      derr    <= 1'b0;
      data_sr <= '0;
      cmd     <= '0;
      tx_sr   <= '0;
      tx_cnt  <= '0;
      sout    <= 1'b1;
    end else begin
      sout <= sout_d;
      case (state)
        IDLE: if (!sin) rx_cnt <= 4'd1;
        RX: begin
          if (!stop_now) begin
            rx_sr  <= {rx_sr[7:0], sin};
            rx_cnt <= rx_cnt + 4'd1;
          end else begin
            rx_cnt <= '0;
            if (!sin)                 derr <= 1'b1;
            else if (frm_type)        cmd  <= payload[6:0];
            else if (frm_cnt == 4'd8) derr <= 1'b1;
            else begin
              frm_cnt <= frm_cnt + 4'd1;
              data_sr <= {data_sr[55:0], payload};
            end
          end
        end
        CALC: begin
          tx_sr  <= packet;
          tx_cnt <= err ? 6'd11 : 6'd55;
        end
        TX: begin
          tx_sr  <= {tx_sr[53:0], 1'b0};
          tx_cnt <= tx_cnt - 6'd1;
          if (tx_cnt == 6'd1) begin
            frm_cnt <= '0;
            derr    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_slave.sv
// Scoreboard bench for alu_serial_slave: the driver pushes expected frames with
// their expected start cycle, an independent monitor decodes sout and compares.
module tb_alu_serial_slave;

  logic clk = 1'b0;
  logic rst_n;
  logic sin;
  logic sout;

  alu_serial_slave dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sin   (sin),
    .sout  (sout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [10:0] frame;
    int          t;
  } exp_t;

  localparam logic [5:0] E_DATA = 6'b100100;
  localparam logic [5:0] E_CRC  = 6'b010010;
  localparam logic [5:0] E_OP   = 6'b001001;

  exp_t        exp_q[$];
  logic [10:0] pend[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          mon_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model --------------------------------------------------------
  // CRC as the remainder of M(x)*x^deg divided by the generator polynomial.
  function automatic logic [3:0] crc_div(input logic [127:0] msg, input int n,
                                         input logic [4:0] poly, input int deg);
    logic [131:0] w;
    w = {4'd0, msg} << deg;
    for (int i = n + deg - 1; i >= deg; i--)
      if (w[i]) w = w ^ ({127'd0, poly} << (i - deg));
    return w[3:0];
  endfunction

  function automatic logic [3:0] cmd_crc(input logic [31:0] a, b, input logic [2:0] op);
    return crc_div({60'd0, b, a, 1'b1, op}, 68, 5'b10011, 4);
  endfunction

  function automatic logic [10:0] err_frame(input logic [5:0] code);
    int   ones;
    logic p;
    ones = 1 + $countones(code);
    p    = (ones % 2) == 1;
    return {1'b0, 1'b1, 1'b1, code, p, 1'b1};
  endfunction

  task automatic model_result(input logic [31:0] a, b, input logic [2:0] op);
    logic [63:0] full;
    longint      s, lim;
    logic [31:0] c;
    logic        cy, v;
    logic [3:0]  flags;
    logic [3:0]  crc3;
    lim = 64'sh80000000;
    cy  = 1'b0;
    v   = 1'b0;
    c   = '0;
    case (op)
      3'd0: c = a & b;
      3'd1: c = a | b;
      3'd4: begin
        full = {32'd0, b} + {32'd0, a};
        c    = full[31:0];
        cy   = full[32];
        s    = longint'($signed(b)) + longint'($signed(a));
        v    = (s >= lim) || (s < -lim);
      end
      default: begin
        c  = b - a;
        cy = a > b;
        s  = longint'($signed(b)) - longint'($signed(a));
        v  = (s >= lim) || (s < -lim);
      end
    endcase
    flags = {cy, v, c == 32'd0, c[31]};
    crc3  = crc_div({91'd0, c, 1'b0, flags}, 37, 5'b01011, 3);
    for (int k = 0; k < 4; k++) pend.push_back({2'b00, c[31 - 8*k -: 8], 1'b1});
    pend.push_back({3'b010, flags, crc3[2:0], 1'b1});
  endtask

  // Driver -----------------------------------------------------------------
  task automatic drive_bit(input logic bv);
    @(negedge clk);
    sin = bv;
  endtask

  task automatic send_frame(input logic typ, input logic [7:0] pay, input logic stop,
                            output int m);
    drive_bit(1'b0);
    drive_bit(typ);
    for (int i = 7; i >= 0; i--) drive_bit(pay[i]);
    drive_bit(stop);
    m = cyc;
  endtask

  // Stop bit driven at cycle m: first response bit is expected at m+3, and the
  // next start bit is offered on the first cycle IDLE can accept it.
  task automatic expect_and_wait(input int m);
    exp_t e;
    for (int k = 0; k < pend.size(); k++) begin
      e.frame = pend[k];
      e.t     = m + 3 + 11 * k;
      exp_q.push_back(e);
    end
    repeat (11 * pend.size() + 1) drive_bit(1'b1);
    pend.delete();
  endtask

  task automatic run_request(input logic [31:0] a, b, input logic [2:0] op,
                             input int n_frames, input bit bad_crc);
    logic [63:0] ba;
    logic [3:0]  crc;
    int          m;
    ba = {b, a};
    for (int i = 0; i < n_frames; i++) send_frame(1'b0, ba[63 - 8*i -: 8], 1'b1, m);
    crc = cmd_crc(a, b, op);
    if (bad_crc) crc = ~crc;
    send_frame(1'b1, {1'b0, op, crc}, 1'b1, m);
    pend.delete();
    if (n_frames != 8)                    pend.push_back(err_frame(E_DATA));
    else if (bad_crc)                     pend.push_back(err_frame(E_CRC));
    else if (!(op inside {3'd0, 3'd1, 3'd4, 3'd5})) pend.push_back(err_frame(E_OP));
    else                                  model_result(a, b, op);
    expect_and_wait(m);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor ----------------------------------------------------------------
  logic [10:0] mon_f;
  int          mon_t;
  exp_t        mon_e;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && rst_n === 1'b1 && sout !== 1'b1) begin
        mon_t     = cyc;
        mon_f[10] = sout;
        for (int i = 9; i >= 0; i--) begin
          @(negedge clk);
          mon_f[i] = sout;
        end
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame: got %b at cycle %0d, expected no frame", mon_f, mon_t);
        end else begin
          mon_e = exp_q.pop_front();
          check("frame_bits", {53'd0, mon_f}, {53'd0, mon_e.frame});
          check("frame_start_cycle", mon_t, mon_e.t);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d frames outstanding", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  // Stimulus ---------------------------------------------------------------
  initial begin
    int          m;
    logic        bit20;
    logic [31:0] ra, rb;
    logic [2:0]  rop;

    sin   = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_sout", sout, 1'b1);
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (10) drive_bit(1'b1);
    check("idle_sout", sout, 1'b1);

    run_request(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd0, 8, 1'b0);  // AND
    run_request(32'h7FFF_FFFF, 32'h0000_0001, 3'd4, 8, 1'b0);  // ADD overflow
    run_request(32'd5, 32'd3, 3'd5, 8, 1'b0);                  // SUB borrow
    run_request(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd0, 8, 1'b1);  // bad CRC
    run_request(32'h1234_5678, 32'h9ABC_DEF0, 3'd2, 8, 1'b0);  // bad opcode
    run_request(32'h1234_5678, 32'h9ABC_DEF0, 3'd4, 7, 1'b0);  // short request

    for (int i = 0; i < 9; i++) send_frame(1'b0, 8'hFF, 1'b1, m);
    pend.push_back(err_frame(E_DATA));
    expect_and_wait(m);
    run_request(32'd1, 32'd1, 3'd4, 8, 1'b0);

    for (int i = 0; i < 3; i++) send_frame(1'b0, 8'hA5, 1'b1, m);
    send_frame(1'b0, 8'h5A, 1'b0, m);                          // bad stop bit
    pend.push_back(err_frame(E_DATA));
    expect_and_wait(m);

    // Reset in the middle of a result packet
    mon_en = 1'b0;
    for (int i = 0; i < 8; i++)
      send_frame(1'b0, {32'h0FF0_0FF0, 32'hF0F0_F0F0} >> (56 - 8*i), 1'b1, m);
    send_frame(1'b1, {1'b0, 3'd0, cmd_crc(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd0)}, 1'b1, m);
    model_result(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd0);
    bit20 = pend[1][1];
    pend.delete();
    repeat (23) drive_bit(1'b1);
    check("tx_bit20", sout, bit20);
    rst_n = 1'b0;
    #1;
    check("async_reset_sout", sout, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) drive_bit(1'b1);
    check("post_reset_idle", sout, 1'b1);
    mon_en = 1'b1;
    run_request(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd0, 8, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ra = pick_operand();
      rb = pick_operand();
      case ($urandom_range(0, 4))
        0:       rop = 3'd0;
        1:       rop = 3'd1;
        2:       rop = 3'd4;
        3:       rop = 3'd5;
        default: rop = 3'($urandom_range(0, 7));
      endcase
      run_request(ra, rb, rop, ($urandom_range(0, 9) == 0) ? 6 : 8,
                  $urandom_range(0, 7) == 0);
    end

    repeat (20) drive_bit(1'b1);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
